// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB data-memory responder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_t;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    // Addresses at or beyond the implemented depth are never aliased onto real words.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input logic [31:0] depth);
        return (addr >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word store: one write or one registered read per cycle.
module dmem_array
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int DEPTH  = 256
) (
    input  logic              Clock,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Word write and registered read; contents deliberately carry no reset.
    always_ff @(posedge Clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_data_mem.sv
// APB completer for the load/store data memory: fixed wait states, range-checked addresses.
module apb_data_mem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam logic       ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD   = 4'(WAIT_STATES);

    apb_state_t        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;
    logic              r_err;
    logic              r_pready;
    logic              r_pslverr;
    logic              r_rd_ok;

    logic              w_setup;
    logic              w_setup_err;
    logic              w_we;
    logic              w_re;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_rdata;

    // Setup detection, range check and the single memory port's address/enables.
    always_comb begin
        w_setup     = (r_state == IDLE) && psel && !penable;
        w_setup_err = addr_out_of_range(32'(paddr), 32'(DEPTH));
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_mem_addr  = r_addr;
        case (r_state)
            IDLE: begin
                // With no wait states the read must use the live setup address.
                w_mem_addr = paddr;
                if (w_setup && ZERO_WAIT && !pwrite && !w_setup_err) begin
                    w_re = 1'b1;
                end else begin
                    w_re = 1'b0;
                end
            end
            WAIT: begin
                if (psel && (r_cnt == 4'd1) && !r_write && !r_err) begin
                    w_re = 1'b1;
                end else begin
                    w_re = 1'b0;
                end
            end
            RESP: begin
                if (psel && penable && r_write && !r_err) begin
                    w_we = 1'b1;
                end else begin
                    w_we = 1'b0;
                end
            end
            default: begin
                w_we = 1'b0;
                w_re = 1'b0;
            end
        endcase
    end

    // Transfer FSM with wait counter, latched request and registered response flags.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_rd_ok   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_addr  <= paddr;
                        r_wdata <= pwdata;
                        r_write <= pwrite;
                        r_err   <= w_setup_err;
                        if (ZERO_WAIT) begin
                            r_state   <= RESP;
                            r_cnt     <= 4'd0;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_setup_err;
                            if (!pwrite) begin
                                r_rd_ok <= !w_setup_err;
                            end
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd1) begin
                        r_state   <= RESP;
                        r_cnt     <= 4'd0;
                        r_pready  <= 1'b1;
                        r_pslverr <= r_err;
                        if (!r_write) begin
                            r_rd_ok <= !r_err;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dmem_array (
        .Clock   (Clock),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_mem_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    // The array's read register holds the last good read; a flop-held qualifier zeroes
    // it after reset and after an out-of-range read, so both sources are registered.
    assign prdata  = r_rd_ok ? w_rdata : '0;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_data_mem.sv
// Self-checking bench: three configurations against an array-based memory model.
module tb_apb_data_mem;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [7:0]  paddr   [3];
    logic [31:0] pwdata  [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    logic [31:0] mdl     [3][256];
    logic [31:0] last_rd [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 Clock = ~Clock;

    apb_data_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_STATES(2)) u_dut_ws2 (
        .Clock(Clock), .Resetn(Resetn), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

    apb_data_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) u_dut_ws0 (
        .Clock(Clock), .Resetn(Resetn), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

    apb_data_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .WAIT_STATES(1)) u_dut_d128 (
        .Clock(Clock), .Resetn(Resetn), .psel(psel[2]), .penable(penable[2]),
        .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]),
        .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

    function automatic int ws_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int dep_of(input int k);
        case (k)
            2:       return 128;
            default: return 256;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete master-side transfer, starting and ending at a falling edge.
    // Request inputs are scrambled during the access phase (alt_addr>=0 forces paddr).
    task automatic xfer(input int k, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input int alt_addr, input string tag);
        int   n;
        logic err;
        err        = (int'(a) >= dep_of(k));
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        pwrite[k]  = wr;
        paddr[k]   = a;
        pwdata[k]  = d;
        @(posedge Clock); @(negedge Clock);
        penable[k] = 1'b1;
        pwrite[k]  = 1'($urandom);
        paddr[k]   = (alt_addr >= 0) ? 8'(alt_addr) : 8'($urandom);
        pwdata[k]  = $urandom;
        n = 2;
        while (pready[k] !== 1'b1 && n < 40) begin
            @(posedge Clock); @(negedge Clock);
            n++;
        end
        if (pready[k] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s timeout: pready observed %b expected 1 within 40 cycles", tag, pready[k]);
        end
        chk({tag, " latency"}, 32'(n), 32'(ws_of(k) + 2));
        chk({tag, " pslverr"}, 32'(pslverr[k]), 32'(err));
        if (!wr) begin
            last_rd[k] = err ? 32'h0 : mdl[k][a];
        end
        chk({tag, " prdata"}, prdata[k], last_rd[k]);
        @(posedge Clock); @(negedge Clock);
        if (wr && !err) begin
            mdl[k][a] = d;
        end
        chk({tag, " pready_drop"}, 32'(pready[k]), 32'h0);
        chk({tag, " pslverr_drop"}, 32'(pslverr[k]), 32'h0);
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
    endtask

    initial begin
        Resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = 8'h00; pwdata[k] = 32'h0; last_rd[k] = 32'h0;
        end
        repeat (3) @(negedge Clock);
        for (int k = 0; k < 3; k++) begin
            chk("reset prdata", prdata[k], 32'h0);
            chk("reset pready", 32'(pready[k]), 32'h0);
            chk("reset pslverr", 32'(pslverr[k]), 32'h0);
        end
        Resetn = 1'b1;
        @(negedge Clock);

        // Give every word a known value (out-of-range writes on the 128-deep copy must be dropped).
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 256; a++) begin
                xfer(k, 1'b1, 8'(a), $urandom, -1, "preload");
            end
        end

        // Two wait states: write then read back.
        xfer(0, 1'b1, 8'h12, 32'hDEADBEEF, -1, "ws2 wr12");
        xfer(0, 1'b0, 8'h12, 32'h0, -1, "ws2 rd12");
        chk("ws2 rd12 value", prdata[0], 32'hDEADBEEF);

        // Zero wait states, back-to-back.
        xfer(1, 1'b1, 8'h00, 32'h1, -1, "ws0 wr00");
        xfer(1, 1'b1, 8'h01, 32'h2, -1, "ws0 wr01");
        xfer(1, 1'b0, 8'h00, 32'h0, -1, "ws0 rd00");
        chk("ws0 rd00 value", prdata[1], 32'h1);
        xfer(1, 1'b0, 8'h01, 32'h0, -1, "ws0 rd01");
        chk("ws0 rd01 value", prdata[1], 32'h2);

        // Depth boundary on the 128-word copy.
        xfer(2, 1'b1, 8'h80, 32'hAAAA5555, -1, "d128 wr80");
        xfer(2, 1'b0, 8'h7F, 32'h0, -1, "d128 rd7f");
        xfer(2, 1'b0, 8'h80, 32'h0, -1, "d128 rd80");
        chk("d128 rd80 value", prdata[2], 32'h0);
        xfer(2, 1'b0, 8'h7F, 32'h0, -1, "d128 rd7f again");
        xfer(2, 1'b0, 8'hFF, 32'h0, -1, "d128 rdff");

        // Abort: drop psel in the first wait cycle; nothing may be written.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h05; pwdata[0] = 32'h1234;
        @(posedge Clock); @(negedge Clock);
        psel[0] = 1'b0;
        repeat (4) begin
            @(posedge Clock); @(negedge Clock);
            chk("abort pready", 32'(pready[0]), 32'h0);
        end
        xfer(0, 1'b0, 8'h05, 32'h0, -1, "abort rd05");

        // Reset during the wait phase of a write.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h06; pwdata[0] = 32'h5A5A;
        @(posedge Clock); @(negedge Clock);
        penable[0] = 1'b1;
        #2 Resetn = 1'b0;
        #1;
        chk("midreset pready", 32'(pready[0]), 32'h0);
        chk("midreset prdata", prdata[0], 32'h0);
        for (int k = 0; k < 3; k++) begin
            last_rd[k] = 32'h0;
        end
        @(negedge Clock);
        psel[0] = 1'b0; penable[0] = 1'b0;
        Resetn = 1'b1;
        @(negedge Clock);
        xfer(0, 1'b0, 8'h06, 32'h0, -1, "postreset rd06");
        xfer(0, 1'b1, 8'h07, 32'h13579BDF, -1, "postreset wr07");
        xfer(0, 1'b0, 8'h07, 32'h0, -1, "postreset rd07");

        // Request inputs move during the access phase.
        xfer(0, 1'b1, 8'h30, 32'hCAFE, 8'h33, "stable wr30");
        xfer(0, 1'b0, 8'h30, 32'h0, -1, "stable rd30");
        chk("stable rd30 value", prdata[0], 32'hCAFE);
        xfer(0, 1'b0, 8'h33, 32'h0, -1, "stable rd33");

        // Random mix across all three configurations.
        for (int i = 0; i < 300; i++) begin
            xfer($urandom_range(0, 2), 1'($urandom), 8'($urandom), $urandom, -1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
